// File: rtl/fsm_cyclic_lamp2_if.sv
// Lamp indicator bundle driven by fsm_cyclic_lamp2.
// Status members exist only when CYCLIC_LAMP_STATUS_EN is defined.
interface fsm_cyclic_lamp2_if;
  logic [0:2] light;
`ifdef CYCLIC_LAMP_STATUS_EN
  logic [1:0] state_code;
  logic       wrap;
`endif

  modport master (
    output light
`ifdef CYCLIC_LAMP_STATUS_EN
    , output state_code
    , output wrap
`endif
  );

  modport slave (
    input light
`ifdef CYCLIC_LAMP_STATUS_EN
    , input state_code
    , input wrap
`endif
  );
endinterface

// File: rtl/fsm_cyclic_lamp2.sv
// Cyclic RED -> GREEN -> YELLOW lamp sequencer with per-lamp dwell counts.
// Optional status outputs (state_code, wrap) under CYCLIC_LAMP_STATUS_EN.
package fsm_cyclic_lamp2_pkg;
  typedef enum logic [1:0] {
    ST_RED    = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10
  } state_t;
endpackage

module fsm_cyclic_lamp2
  import fsm_cyclic_lamp2_pkg::*;
#(
  parameter int unsigned RED_CYCLES    = 1,
  parameter int unsigned GREEN_CYCLES  = 1,
  parameter int unsigned YELLOW_CYCLES = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  fsm_cyclic_lamp2_if.master lamp
);

  // Zero dwell counts behave as one cycle.
  localparam int unsigned RED_N    = (RED_CYCLES    == 0) ? 1 : RED_CYCLES;
  localparam int unsigned GREEN_N  = (GREEN_CYCLES  == 0) ? 1 : GREEN_CYCLES;
  localparam int unsigned YELLOW_N = (YELLOW_CYCLES == 0) ? 1 : YELLOW_CYCLES;
  localparam int unsigned RG_N     = (RED_N > GREEN_N) ? RED_N : GREEN_N;
  localparam int unsigned MAX_N    = (RG_N > YELLOW_N) ? RG_N : YELLOW_N;
  localparam int unsigned CNT_W    = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_N - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_N - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
`ifdef CYCLIC_LAMP_STATUS_EN
  logic             wrap_q;
`endif

  // State and dwell counter; unused encodings fall back to RED with a cleared counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_RED;
      cnt    <= '0;
`ifdef CYCLIC_LAMP_STATUS_EN
      wrap_q <= 1'b0;
`endif
    end else begin
`ifdef CYCLIC_LAMP_STATUS_EN
      wrap_q <= 1'b0;
`endif
      case (state)
        ST_RED: begin
          if (cnt == RED_LAST) begin
            state <= ST_GREEN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_GREEN: begin
          if (cnt == GREEN_LAST) begin
            state <= ST_YELLOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_YELLOW: begin
          if (cnt == YELLOW_LAST) begin
            state  <= ST_RED;
            cnt    <= '0;
`ifdef CYCLIC_LAMP_STATUS_EN
            wrap_q <= 1'b1;
`endif
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_RED;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Lamp drive is a pure decode of the state register; unused codes show RED.
  always_comb begin
    lamp.light = 3'b100;
    case (state)
      ST_GREEN:  lamp.light = 3'b010;
      ST_YELLOW: lamp.light = 3'b001;
      default:   lamp.light = 3'b100;
    endcase
  end

`ifdef CYCLIC_LAMP_STATUS_EN
  always_comb begin
    lamp.state_code = 2'b00;
    case (state)
      ST_GREEN:  lamp.state_code = 2'b01;
      ST_YELLOW: lamp.state_code = 2'b10;
      default:   lamp.state_code = 2'b00;
    endcase
  end

  assign lamp.wrap = wrap_q;
`endif

endmodule

// File: tb/tb_fsm_cyclic_lamp2.sv
// Bench for fsm_cyclic_lamp2: four parameter sets against an arithmetic
// position-in-cycle model; status outputs checked when CYCLIC_LAMP_STATUS_EN is set.
module tb_fsm_cyclic_lamp2;
  localparam int NI = 4;
  localparam int RC [NI] = '{1, 3, 4, 0};
  localparam int GC [NI] = '{1, 2, 7, 2};
  localparam int YC [NI] = '{1, 1, 2, 0};

  logic          clock;
  logic [NI-1:0] rst_n;

  fsm_cyclic_lamp2_if if_def ();
  fsm_cyclic_lamp2_if if_a ();
  fsm_cyclic_lamp2_if if_b ();
  fsm_cyclic_lamp2_if if_z ();

  fsm_cyclic_lamp2 u_def (.clock(clock), .reset_n(rst_n[0]), .lamp(if_def));
  fsm_cyclic_lamp2 #(.RED_CYCLES(3), .GREEN_CYCLES(2), .YELLOW_CYCLES(1))
    u_a (.clock(clock), .reset_n(rst_n[1]), .lamp(if_a));
  fsm_cyclic_lamp2 #(.RED_CYCLES(4), .GREEN_CYCLES(7), .YELLOW_CYCLES(2))
    u_b (.clock(clock), .reset_n(rst_n[2]), .lamp(if_b));
  fsm_cyclic_lamp2 #(.RED_CYCLES(0), .GREEN_CYCLES(2), .YELLOW_CYCLES(0))
    u_z (.clock(clock), .reset_n(rst_n[3]), .lamp(if_z));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int n   [NI];
  bit ill [NI];
  bit hit [NI];

  typedef struct {
    logic [0:2] l_def;
    logic [0:2] l_a;
    logic [0:2] l_z;
    logic [1:0] sc_def;
    logic       wrap_def;
  } vec_t;
  vec_t tbl [7];

  function automatic logic [0:2] get_light(input int i);
    case (i)
      0:       return if_def.light;
      1:       return if_a.light;
      2:       return if_b.light;
      default: return if_z.light;
    endcase
  endfunction

`ifdef CYCLIC_LAMP_STATUS_EN
  function automatic logic [1:0] get_sc(input int i);
    case (i)
      0:       return if_def.state_code;
      1:       return if_a.state_code;
      2:       return if_b.state_code;
      default: return if_z.state_code;
    endcase
  endfunction

  function automatic logic get_wrap(input int i);
    case (i)
      0:       return if_def.wrap;
      1:       return if_a.wrap;
      2:       return if_b.wrap;
      default: return if_z.wrap;
    endcase
  endfunction
`endif

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int period(input int i);
    return eff(RC[i]) + eff(GC[i]) + eff(YC[i]);
  endfunction

  // n = rising edges since reset release (or since illegal-state recovery)
  function automatic logic [0:2] exp_light(input int i, input int cnt);
    int p;
    p = cnt % period(i);
    if (p < eff(RC[i])) return 3'b100;
    if (p < eff(RC[i]) + eff(GC[i])) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [1:0] exp_sc(input int i, input int cnt);
    logic [0:2] l;
    l = exp_light(i, cnt);
    if (l == 3'b010) return 2'b01;
    if (l == 3'b001) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic exp_wrap(input int i, input int cnt);
    return (cnt > 0) && ((cnt % period(i)) == 0);
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t actual=%b expected=%b", nm, i, $time, act[2:0], exp[2:0]);
    end
  endtask

  task automatic step();
    @(posedge clock);
    for (int i = 0; i < NI; i++) begin
      if (!rst_n[i]) n[i] = 0;
      else if (ill[i]) begin n[i] = 0; ill[i] = 1'b0; end
      else n[i]++;
    end
    #2;
  endtask

  task automatic check_model();
    for (int i = 0; i < NI; i++) begin
      if (!ill[i]) begin
        chk("light", i, 32'(get_light(i)), 32'(exp_light(i, n[i])));
`ifdef CYCLIC_LAMP_STATUS_EN
        chk("state_code", i, 32'(get_sc(i)), 32'(exp_sc(i, n[i])));
        chk("wrap", i, 32'(get_wrap(i)), 32'(exp_wrap(i, n[i])));
`endif
      end
    end
  endtask

  initial begin
    rst_n = '0;
    for (int i = 0; i < NI; i++) begin n[i] = 0; ill[i] = 1'b0; hit[i] = 1'b0; end
    tbl[0] = '{3'b010, 3'b100, 3'b010, 2'b01, 1'b0};
    tbl[1] = '{3'b001, 3'b100, 3'b010, 2'b10, 1'b0};
    tbl[2] = '{3'b100, 3'b010, 3'b001, 2'b00, 1'b1};
    tbl[3] = '{3'b010, 3'b010, 3'b100, 2'b01, 1'b0};
    tbl[4] = '{3'b001, 3'b001, 3'b010, 2'b10, 1'b0};
    tbl[5] = '{3'b100, 3'b100, 3'b010, 2'b00, 1'b1};
    tbl[6] = '{3'b010, 3'b100, 3'b001, 2'b01, 1'b0};

    // reset values before any clock and after an edge under reset
    #1;
    for (int i = 0; i < NI; i++) chk("reset_light", i, 32'(get_light(i)), 32'(3'b100));
    #9;
    for (int i = 0; i < NI; i++) begin
      chk("reset_light_hold", i, 32'(get_light(i)), 32'(3'b100));
`ifdef CYCLIC_LAMP_STATUS_EN
      chk("reset_sc", i, 32'(get_sc(i)), 32'(2'b00));
      chk("reset_wrap", i, 32'(get_wrap(i)), 32'(1'b0));
`endif
    end
    #2 rst_n = '1;

    // fixed expected sequences after release
    for (int k = 0; k < 7; k++) begin
      step();
      chk("tbl_def", 0, 32'(get_light(0)), 32'(tbl[k].l_def));
      chk("tbl_a", 1, 32'(get_light(1)), 32'(tbl[k].l_a));
      chk("tbl_z", 3, 32'(get_light(3)), 32'(tbl[k].l_z));
`ifdef CYCLIC_LAMP_STATUS_EN
      chk("tbl_sc", 0, 32'(get_sc(0)), 32'(tbl[k].sc_def));
      chk("tbl_wrap", 0, 32'(get_wrap(0)), 32'(tbl[k].wrap_def));
`endif
      check_model();
    end

    // asynchronous reset mid-GREEN on the 3/2/1 instance
    for (int k = 0; k < 20 && exp_light(1, n[1]) != 3'b010; k++) begin
      step();
      check_model();
    end
    chk("pre_rst_green", 1, 32'(get_light(1)), 32'(3'b010));
    #1 rst_n[1] = 1'b0;
    n[1] = 0;
    #1 chk("async_rst_now", 1, 32'(get_light(1)), 32'(3'b100));
    step();
    check_model();
    #1 rst_n[1] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      check_model();
    end

    // unused state encoding on two instances
    for (int k = 0; k < 20 && exp_light(1, n[1]) != 3'b010; k++) begin
      step();
      check_model();
    end
    #1;
    force u_def.state = fsm_cyclic_lamp2_pkg::state_t'(2'b11);
    force u_a.state = fsm_cyclic_lamp2_pkg::state_t'(2'b11);
    #1;
    chk("illegal_now", 0, 32'(get_light(0)), 32'(3'b100));
    chk("illegal_now", 1, 32'(get_light(1)), 32'(3'b100));
    release u_def.state;
    release u_a.state;
    ill[0] = 1'b1;
    ill[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check_model();
    end

    // randomized resets over 1000 cycles
    for (int cyc = 0; cyc < 1000; cyc++) begin
      step();
      check_model();
      for (int i = 0; i < NI; i++) begin
        logic [0:2] l;
        l = get_light(i);
        chk("onehot", i, 32'($countones(l)), 32'd1);
      end
      #1;
      for (int i = 0; i < NI; i++) begin
        if (!rst_n[i]) rst_n[i] = 1'b1;
        else if ($urandom_range(0, 39) == 0) begin
          rst_n[i] = 1'b0;
          n[i] = 0;
          hit[i] = 1'b1;
        end
      end
      #1;
      for (int i = 0; i < NI; i++) begin
        if (hit[i]) begin
          chk("async_rand", i, 32'(get_light(i)), 32'(3'b100));
          if ($urandom_range(0, 1) == 1) rst_n[i] = 1'b1;
          hit[i] = 1'b0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
